nios2_mult_unit: RTL and testbench
==================================

// Module: nios2_mult_unit
// PURPOSE
//  Parametrised, pipelined integer multiply unit for the Nios II-class execute/memory path.
//  Builds a full 2*DATA_W product from four registered HALF x HALF partial products.
//  Supports signed and unsigned operands and low/high result selection (MUL, MULXUU, MULXSU, MULXSS).
//  Has a stall enable, flush, and a tag sideband, so the CPU pipeline can track results in flight.
// PARAMETERS
//  DATA_W  32  operand/result width; even, 8..64; HALF = DATA_W/2
//  TAG_W   5   sideband tag width (destination register index)
// PORTS
//  clk         in   1        clock, all state rises on posedge
//  reset       in   1        asynchronous, active-high; clears all state
//  en          in   1        pipeline advance; 0 = every stage holds
//  flush       in   1        synchronous; clears all stage valids when high
//  in_valid    in   1        operation presented on in_* this cycle
//  in_op       in   2        00 MUL(low), 01 MULXUU, 10 MULXSU, 11 MULXSS (high)
//  in_a        in   DATA_W   operand A (signed for SU/SS)
//  in_b        in   DATA_W   operand B (signed for SS only)
//  in_tag      in   TAG_W    sideband, returned with result
//  out_valid   out  1        out_result/out_tag valid
//  out_result  out  DATA_W   selected product word
//  out_tag     out  TAG_W    tag of the completing op
//  busy        out  1        OR of all stage valids
// BEHAVIOUR
//  - Reset: all stage valids = 0; out_valid = 0, out_result = 0, out_tag = 0, busy = 0.
//  - Three stages, each advancing only when en = 1. Latency is 3 en-cycles from in_valid to out_valid.
//    No bubbles are inserted, and throughput is 1 op per en-cycle.
//  - Input is accepted only when in_valid & en; in_* is ignored otherwise.
//  - S1 registers the four unsigned products, each 2*HALF bits:
//    aL*bL, aL*bH, aH*bL, aH*bH.
//    S1 also registers op, tag, a_neg = a[MSB] & op[1], and b_neg = b[MSB] & (op == 11).
//  - S1 also registers correction terms: corrA = a_neg ? b : 0 and corrB = b_neg ? a : 0.
//  - S2 forms the 2*DATA_W sum, truncated to 2*DATA_W bits:
//    P = aL*bL + (aL*bH + aH*bL) << HALF + aH*bH << DATA_W - (corrA + corrB) << DATA_W
//  - S3 output: op == 00 -> P[DATA_W-1:0]; otherwise -> P[2*DATA_W-1:DATA_W].
//    out_result and out_tag are registered and hold their value while out_valid = 0 or en = 0.
//  - en = 0: all stage registers, including out_valid, hold.
//    A result already at the output stays asserted until en returns.
//  - flush = 1: at the next edge, every stage valid is cleared, including an in_valid presented that cycle.
//    flush takes priority over en. Data registers are don't-care after a flush.
//  - out_valid is a pulse per completing op when en = 1. The consumer samples it when out_valid & en.
//  - reset mid-operation: all in-flight ops are discarded immediately.
//    The first accepted op after reset deassertion completes 3 en-cycles later.
//  - Arithmetic is modulo 2^(2*DATA_W). There is no overflow flag.
//    MUL low word is identical for every signedness.
// TESTING
//  - MULXUU a=b=0xFFFFFFFF, en held -> out_valid on 3rd edge after accept, out_result=0xFFFFFFFE.
//  - Same operands, ops MUL/MULXSS/MULXSU issued back-to-back -> 0x00000001, 0x00000000, 0xFFFFFFFF
//    on 3 consecutive cycles, tags in order.
//  - MULXSS a=b=0x80000000 -> 0x40000000. MULXUU a=b=0x00010000 -> 0x00000001.
//    MUL with the same operands -> 0x00000000.
//  - Issue 3 ops, drop en for 4 cycles mid-flight -> no result lost or duplicated, busy=1 throughout.
//    Results resume in order once en=1.
//  - Assert flush with 2 ops in flight plus an op presented on in_* -> no out_valid for those ops, busy=0 next cycle.
//  - Assert reset for 1 cycle with 3 ops in flight -> out_valid=0 and busy=0 immediately.
//    Random 10k-op regression vs reference model for DATA_W=16 and DATA_W=32.

Source files
------------

// File: rtl/nios2_mult_unit.sv
// Three-stage pipelined DATA_W x DATA_W multiplier built from four HALF x HALF partial products.
// Supports MUL (low word) and MULXUU/MULXSU/MULXSS (high word), with stall, flush and a tag sideband.
module nios2_mult_unit #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [1:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  localparam int HALF = DATA_W / 2;
  localparam int PW   = 2 * DATA_W;

  function automatic logic [DATA_W-1:0] sel_word(input logic [1:0] op, input logic [PW-1:0] p);
    if (op == 2'b00) return p[DATA_W-1:0];
    else             return p[PW-1:DATA_W];
  endfunction

  logic [DATA_W-1:0] a_lo, a_hi, b_lo, b_hi;
  logic              a_neg, b_neg;

  assign a_lo  = {{HALF{1'b0}}, in_a[HALF-1:0]};
  assign a_hi  = {{HALF{1'b0}}, in_a[DATA_W-1:HALF]};
  assign b_lo  = {{HALF{1'b0}}, in_b[HALF-1:0]};
  assign b_hi  = {{HALF{1'b0}}, in_b[DATA_W-1:HALF]};
  assign a_neg = in_a[DATA_W-1] & in_op[1];
  assign b_neg = in_b[DATA_W-1] & (in_op == 2'b11);

  logic              vld_p1, vld_p2;
  logic [DATA_W-1:0] ll_p1, lh_p1, hl_p1, hh_p1;
  logic [DATA_W-1:0] corr_a_p1, corr_b_p1;
  logic [1:0]        op_p1, op_p2;
  logic [TAG_W-1:0]  tag_p1, tag_p2;
  logic [PW-1:0]     p_p2;

  // Signed operands are handled by subtracting the two's-complement corrections from the high word.
  logic [DATA_W:0]   mid_sum;
  logic [DATA_W-1:0] corr_sum;
  logic [PW-1:0]     p_sum;

  always_comb begin
    mid_sum  = {1'b0, lh_p1} + {1'b0, hl_p1};
    corr_sum = corr_a_p1 + corr_b_p1;
    p_sum    = {{DATA_W{1'b0}}, ll_p1}
             + ({{(DATA_W-1){1'b0}}, mid_sum} << HALF)
             + {hh_p1, {DATA_W{1'b0}}}
             - {corr_sum, {DATA_W{1'b0}}};
  end

  // Control path: valids plus the architecturally visible output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1     <= 1'b0;
      vld_p2     <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      vld_p1    <= in_valid;
      vld_p2    <= vld_p1;
      out_valid <= vld_p2;
      // Stage 3: select low or high product word
      if (vld_p2) begin
        out_result <= sel_word(op_p2, p_p2);
        out_tag    <= tag_p2;
      end
    end
  end

  always_ff @(posedge clk) begin
    // Stage 1: partial products and correction terms
    if (en && in_valid) begin
      ll_p1     <= a_lo * b_lo;
      lh_p1     <= a_lo * b_hi;
      hl_p1     <= a_hi * b_lo;
      hh_p1     <= a_hi * b_hi;
      corr_a_p1 <= a_neg ? in_b : '0;
      corr_b_p1 <= b_neg ? in_a : '0;
      op_p1     <= in_op;
      tag_p1    <= in_tag;
    end
    // Stage 2: full-width product sum
    if (en && vld_p1) begin
      p_p2   <= p_sum;
      op_p2  <= op_p1;
      tag_p2 <= tag_p1;
    end
  end

  assign busy = vld_p1 | vld_p2 | out_valid;

endmodule

// File: tb/tb_nios2_mult_unit.sv
// Directed and short randomized checks of nios2_mult_unit at DATA_W=32, TAG_W=5.
module tb_nios2_mult_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        busy;

  int total = 0;
  int bad = 0;

  nios2_mult_unit #(.DATA_W(32), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .in_valid(in_valid), .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_result(out_result), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  // Reference: plain 64-bit modular multiply of sign/zero-extended operands.
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax, bx, p;
    ax = op[1] ? {{32{a[31]}}, a} : {32'h0, a};
    bx = (op == 2'b11) ? {{32{b[31]}}, b} : {32'h0, b};
    p  = ax * bx;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    en = 1'b1;
    drive(1'b1, 2'b01, 32'h1234, 32'h5678, 5'd9);
    tick();
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (out_result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", out_result); end
    total++; if (out_tag !== 5'd0) begin bad++; $display("FAIL reset_tag got=%0d want=0", out_tag); end
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_latency();
    en = 1'b1;
    drive(1'b1, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_e1 got=%0b want=0", out_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL lat_busy got=%0b want=1", busy); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_e2 got=%0b want=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_e3 got=%0b want=1", out_valid); end
    total++; if (out_result !== 32'hFFFFFFFE) begin bad++; $display("FAIL lat_result got=%h want=fffffffe", out_result); end
    total++; if (out_tag !== 5'd3) begin bad++; $display("FAIL lat_tag got=%0d want=3", out_tag); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_pulse got=%0b want=0", out_valid); end
    total++; if (out_result !== 32'hFFFFFFFE) begin bad++; $display("FAIL lat_hold got=%h want=fffffffe", out_result); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_r [3];
    logic [1:0]  ops   [3];
    ops[0] = 2'b00; ops[1] = 2'b11; ops[2] = 2'b10;
    exp_r[0] = 32'h00000001; exp_r[1] = 32'h00000000; exp_r[2] = 32'hFFFFFFFF;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ops[i], 32'hFFFFFFFF, 32'hFFFFFFFF, 5'(i + 1));
      tick();
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid !== 1'b1 || out_result !== exp_r[i] || out_tag !== 5'(i + 1)) begin
        bad++; $display("FAIL b2b_%0d got v=%0b r=%h t=%0d want v=1 r=%h t=%0d", i, out_valid, out_result, out_tag, exp_r[i], i + 1);
      end
      tick();
    end
  endtask

  task automatic test_corners();
    logic [31:0] a_v [3];
    logic [31:0] exp_r [3];
    logic [1:0]  ops [3];
    a_v[0] = 32'h80000000; ops[0] = 2'b11; exp_r[0] = 32'h40000000;
    a_v[1] = 32'h00010000; ops[1] = 2'b01; exp_r[1] = 32'h00000001;
    a_v[2] = 32'h00010000; ops[2] = 2'b00; exp_r[2] = 32'h00000000;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, ops[i], a_v[i], a_v[i], 5'(i + 4));
      tick();
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      total++; if (out_valid !== 1'b1 || out_result !== exp_r[i] || out_tag !== 5'(i + 4)) begin
        bad++; $display("FAIL corner_%0d got v=%0b r=%h t=%0d want v=1 r=%h t=%0d", i, out_valid, out_result, out_tag, exp_r[i], i + 4);
      end
      tick();
    end
  endtask

  task automatic test_stall();
    en = 1'b1;
    drive(1'b1, 2'b00, 32'd3, 32'd5, 5'd7);
    tick();
    drive(1'b1, 2'b00, 32'd7, 32'd11, 5'd8);
    tick();
    drive(1'b1, 2'b01, 32'h80000000, 32'd4, 5'd9);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    total++; if (out_valid !== 1'b1 || out_result !== 32'd15 || out_tag !== 5'd7) begin
      bad++; $display("FAIL stall_first got v=%0b r=%h t=%0d want v=1 r=0000000f t=7", out_valid, out_result, out_tag);
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (out_valid !== 1'b1 || out_result !== 32'd15 || busy !== 1'b1) begin
        bad++; $display("FAIL stall_hold_%0d got v=%0b r=%h busy=%0b want v=1 r=0000000f busy=1", i, out_valid, out_result, busy);
      end
    end
    en = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1 || out_result !== 32'd77 || out_tag !== 5'd8) begin
      bad++; $display("FAIL stall_second got v=%0b r=%h t=%0d want v=1 r=0000004d t=8", out_valid, out_result, out_tag);
    end
    tick();
    total++; if (out_valid !== 1'b1 || out_result !== 32'd2 || out_tag !== 5'd9) begin
      bad++; $display("FAIL stall_third got v=%0b r=%h t=%0d want v=1 r=00000002 t=9", out_valid, out_result, out_tag);
    end
    tick();
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL stall_drain got v=%0b busy=%0b want v=0 busy=0", out_valid, busy);
    end
  endtask

  task automatic test_flush();
    en = 1'b1;
    drive(1'b1, 2'b00, 32'd2, 32'd3, 5'd10);
    tick();
    drive(1'b1, 2'b00, 32'd4, 32'd5, 5'd11);
    tick();
    drive(1'b1, 2'b00, 32'd6, 32'd7, 5'd12);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL flush_now got v=%0b busy=%0b want v=0 busy=0", out_valid, busy);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_after_%0d got v=%0b want v=0", i, out_valid); end
    end
  endtask

  task automatic test_reset_midflight();
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b00, 32'd9, 32'(i + 1), 5'(i + 20));
      tick();
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    #2 reset = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 32'h0) begin
      bad++; $display("FAIL rst_mid got v=%0b busy=%0b r=%h want v=0 busy=0 r=0", out_valid, busy, out_result);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    drive(1'b1, 2'b01, 32'h00010000, 32'h00010000, 5'd12);
    tick();
    drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_early got v=%0b want v=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || out_result !== 32'd1 || out_tag !== 5'd12) begin
      bad++; $display("FAIL rst_after got v=%0b r=%h t=%0d want v=1 r=00000001 t=12", out_valid, out_result, out_tag);
    end
    tick();
  endtask

  task automatic test_random();
    logic [36:0] q [$];
    logic [36:0] e;
    logic [31:0] corner [4];
    corner[0] = 32'h80000000; corner[1] = 32'hFFFFFFFF; corner[2] = 32'h7FFFFFFF; corner[3] = 32'h00000000;
    for (int i = 0; i < 420; i++) begin
      if (i < 400) begin
        en       = ($urandom_range(0, 3) != 0);
        in_valid = $urandom_range(0, 1);
        in_op    = 2'($urandom_range(0, 3));
        in_a     = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
        in_b     = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
        in_tag   = 5'(i);
      end else begin
        en = 1'b1;
        drive(1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
      end
      if (out_valid && en) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rnd_extra got r=%h t=%0d want no result", out_result, out_tag);
        end else begin
          e = q.pop_front();
          if (out_result !== e[31:0] || out_tag !== e[36:32]) begin
            bad++; $display("FAIL rnd_%0d got r=%h t=%0d want r=%h t=%0d", i, out_result, out_tag, e[31:0], e[36:32]);
          end
        end
      end
      if (in_valid && en) q.push_back({in_tag, ref_mul(in_op, in_a, in_b)});
      tick();
    end
    total++; if (q.size() != 0) begin bad++; $display("FAIL rnd_lost got pending=%0d want 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_corners();
    test_stall();
    test_flush();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
